// File: rtl/fetch_unit_if.sv
// Memory-side and decode-side signals of the fetch stage bundled together.
interface fetch_unit_if;
  logic [31:0] mem_address;
  logic        mem_read_write;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_fault;
  logic [31:0] fault_pc;

  // Fetch unit side
  modport master (
    output mem_address, mem_read_write, mem_data_in,
    output inst_valid, inst, inst_pc,
    output fetch_fault, fault_pc,
    input  mem_data_out, inst_ready, redirect_valid, redirect_pc
  );

  // Memory / decode / branch side
  modport slave (
    input  mem_address, mem_read_write, mem_data_in,
    input  inst_valid, inst, inst_pc,
    input  fetch_fault, fault_pc,
    output mem_data_out, inst_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads memory, buffers words in a
// small prefetch FIFO and hands them to decode with valid/ready.
module fetch_unit #(
  parameter logic [31:0] STARTING_ADDR = 32'h0100_0000,
  parameter logic [31:0] MEM_BYTES     = 32'h0010_0000,
  parameter int unsigned DEPTH         = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  fetch_unit_if.master bus
);

  localparam int unsigned PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam logic [31:0] LAST_ADDR = STARTING_ADDR + MEM_BYTES - 32'd4;

  typedef enum logic [0:0] {ST_FETCH, ST_FAULT} state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic               fetch_fault_q, fetch_fault_d;
  logic [31:0]        fault_pc_q, fault_pc_d;
  logic [31:0]        fifo_pc_q   [DEPTH];
  logic [31:0]        fifo_pc_d   [DEPTH];
  logic [31:0]        fifo_inst_q [DEPTH];
  logic [31:0]        fifo_inst_d [DEPTH];

  logic               inst_valid_c;
  logic               pc_legal_c;
  logic               push_c;
  logic               pop_c;

  // Head is visible unless a redirect is flushing the FIFO this cycle
  assign inst_valid_c = (count_q != '0) && !bus.redirect_valid;
  assign pc_legal_c   = (pc_q[1:0] == 2'b00) && (pc_q >= STARTING_ADDR) && (pc_q <= LAST_ADDR);

  // Next-state, FIFO and PC update
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    fetch_fault_d = fetch_fault_q;
    fault_pc_d    = fault_pc_q;
    fifo_pc_d     = fifo_pc_q;
    fifo_inst_d   = fifo_inst_q;
    push_c        = 1'b0;
    pop_c         = 1'b0;

    if (bus.redirect_valid) begin
      state_d       = ST_FETCH;
      pc_d          = bus.redirect_pc;
      count_d       = '0;
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
      fetch_fault_d = 1'b0;
    end else begin
      pop_c = inst_valid_c && bus.inst_ready;

      unique case (state_q)
        ST_FETCH: begin
          if (pc_legal_c) begin
            push_c = (count_q < CNT_W'(DEPTH)) || pop_c;
          end else begin
            state_d       = ST_FAULT;
            fault_pc_d    = pc_q;
            fetch_fault_d = 1'b1;
          end
        end
        ST_FAULT: begin
        end
        default: begin
          state_d = ST_FETCH;
        end
      endcase

      if (push_c) begin
        fifo_pc_d[wr_ptr_q]   = pc_q;
        fifo_inst_d[wr_ptr_q] = bus.mem_data_out;
        wr_ptr_d              = wr_ptr_q + PTR_W'(1);
        pc_d                  = pc_q + 32'd4;
      end
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push_c && !pop_c) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop_c && !push_c) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_FETCH;
      pc_q          <= STARTING_ADDR;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      fetch_fault_q <= 1'b0;
      fault_pc_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_pc_q[i]   <= '0;
        fifo_inst_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      fetch_fault_q <= fetch_fault_d;
      fault_pc_q    <= fault_pc_d;
      fifo_pc_q     <= fifo_pc_d;
      fifo_inst_q   <= fifo_inst_d;
    end
  end

  assign bus.mem_address    = pc_q;
  assign bus.mem_read_write = 1'b0;
  assign bus.mem_data_in    = 32'h0;
  assign bus.inst_valid     = inst_valid_c;
  assign bus.inst           = fifo_inst_q[rd_ptr_q];
  assign bus.inst_pc        = fifo_pc_q[rd_ptr_q];
  assign bus.fetch_fault    = fetch_fault_q;
  assign bus.fault_pc       = fault_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a combinational memory model.
module tb_fetch_unit;

  localparam logic [31:0] A0 = 32'h0100_0000;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  fetch_unit_if bus_if ();

  fetch_unit dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus_if)
  );

  // Memory contents: each word is a fixed scramble of its own address
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'h5A5A_1234;
  endfunction

  assign bus_if.mem_data_out = word_at(bus_if.mem_address);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired obs=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus_if.inst_ready     = 1'b1;
    bus_if.redirect_valid = 1'b0;
    bus_if.redirect_pc    = 32'h0;
    step();
    step();
    rst_n = 1'b1;
    #1;

    // Reset values
    chk("rst_addr",  bus_if.mem_address,           A0);
    chk("rst_valid", 32'(bus_if.inst_valid),       32'd0);
    chk("rst_inst",  bus_if.inst,                  32'd0);
    chk("rst_ipc",   bus_if.inst_pc,               32'd0);
    chk("rst_fault", 32'(bus_if.fetch_fault),      32'd0);
    chk("rst_fpc",   bus_if.fault_pc,              32'd0);
    chk("rst_rw",    32'(bus_if.mem_read_write),   32'd0);
    chk("rst_din",   bus_if.mem_data_in,           32'd0);

    // Streaming with ready=1: one word per cycle, first one a cycle after reset
    for (int k = 0; k < 4; k++) begin
      step();
      chk("seq_valid", 32'(bus_if.inst_valid), 32'd1);
      chk("seq_ipc",   bus_if.inst_pc, A0 + 32'(4 * k));
      chk("seq_inst",  bus_if.inst,    word_at(A0 + 32'(4 * k)));
    end
    chk("seq_addr", bus_if.mem_address, A0 + 32'd16);

    // Backpressure: head holds A0+12, one more word fills the FIFO, pc stalls
    bus_if.inst_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("stall_ipc",   bus_if.inst_pc,  A0 + 32'd12);
      chk("stall_inst",  bus_if.inst,     word_at(A0 + 32'd12));
      chk("stall_valid", 32'(bus_if.inst_valid), 32'd1);
    end
    chk("stall_addr", bus_if.mem_address, A0 + 32'd20);

    // Release: words continue in order with no gap or duplicate
    bus_if.inst_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("drain_ipc",  bus_if.inst_pc, A0 + 32'd16 + 32'(4 * k));
      chk("drain_inst", bus_if.inst,    word_at(A0 + 32'd16 + 32'(4 * k)));
    end

    // Redirect while full: valid low in the redirect cycle, flushed afterwards
    bus_if.inst_ready = 1'b0;
    step();
    chk("full_valid", 32'(bus_if.inst_valid), 32'd1);
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = A0 + 32'h40;
    #1;
    chk("redir_valid_same", 32'(bus_if.inst_valid), 32'd0);
    step();
    bus_if.redirect_valid = 1'b0;
    #1;
    chk("redir_addr",  bus_if.mem_address,          A0 + 32'h40);
    chk("redir_flush", 32'(bus_if.inst_valid),      32'd0);
    bus_if.inst_ready = 1'b1;
    step();
    chk("redir_tvalid", 32'(bus_if.inst_valid), 32'd1);
    chk("redir_tipc",   bus_if.inst_pc, A0 + 32'h40);
    chk("redir_tinst",  bus_if.inst,    word_at(A0 + 32'h40));

    // Misaligned redirect target faults one cycle after it is presented
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = A0 + 32'h42;
    step();
    bus_if.redirect_valid = 1'b0;
    #1;
    chk("mis_addr",    bus_if.mem_address,     A0 + 32'h42);
    chk("mis_nofault", 32'(bus_if.fetch_fault), 32'd0);
    step();
    chk("mis_fault",   32'(bus_if.fetch_fault), 32'd1);
    chk("mis_fpc",     bus_if.fault_pc,         A0 + 32'h42);
    chk("mis_valid",   32'(bus_if.inst_valid),  32'd0);
    step();
    chk("mis_hold",    32'(bus_if.fetch_fault), 32'd1);
    chk("mis_nopush",  32'(bus_if.inst_valid),  32'd0);
    chk("mis_pchold",  bus_if.mem_address,      A0 + 32'h42);

    // Redirect to a legal address clears the fault and fetching resumes
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = A0;
    step();
    bus_if.redirect_valid = 1'b0;
    #1;
    chk("clr_fault", 32'(bus_if.fetch_fault), 32'd0);
    chk("clr_addr",  bus_if.mem_address,      A0);
    step();
    chk("clr_valid", 32'(bus_if.inst_valid),  32'd1);
    chk("clr_ipc",   bus_if.inst_pc,          A0);

    // End of window: last two legal words buffered, then fault at 0x01100000
    bus_if.inst_ready     = 1'b0;
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = 32'h010F_FFF8;
    step();
    bus_if.redirect_valid = 1'b0;
    step();
    step();
    chk("eow_addr",  bus_if.mem_address, 32'h0110_0000);
    step();
    chk("eow_fault", 32'(bus_if.fetch_fault), 32'd1);
    chk("eow_fpc",   bus_if.fault_pc,         32'h0110_0000);
    chk("eow_ipc0",  bus_if.inst_pc,          32'h010F_FFF8);
    bus_if.inst_ready = 1'b1;
    step();
    chk("eow_valid1", 32'(bus_if.inst_valid), 32'd1);
    chk("eow_ipc1",   bus_if.inst_pc,         32'h010F_FFFC);
    chk("eow_inst1",  bus_if.inst,            word_at(32'h010F_FFFC));
    step();
    chk("eow_empty",  32'(bus_if.inst_valid), 32'd0);
    chk("eow_still",  32'(bus_if.fetch_fault), 32'd1);

    // Asynchronous reset with two entries buffered
    bus_if.inst_ready     = 1'b0;
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = A0 + 32'h100;
    step();
    bus_if.redirect_valid = 1'b0;
    step();
    step();
    chk("ar_pre_valid", 32'(bus_if.inst_valid), 32'd1);
    chk("ar_pre_addr",  bus_if.mem_address,     A0 + 32'h108);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(bus_if.inst_valid), 32'd0);
    chk("ar_addr",  bus_if.mem_address,     A0);
    chk("ar_ipc",   bus_if.inst_pc,         32'd0);
    step();
    rst_n = 1'b1;
    bus_if.inst_ready = 1'b1;
    step();
    chk("ar_r_ipc0", bus_if.inst_pc, A0);
    chk("ar_r_inst0", bus_if.inst,   word_at(A0));
    step();
    chk("ar_r_ipc1", bus_if.inst_pc, A0 + 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
